// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

  // Prefix FSM: which of E0 / F0 have been seen since the last emitted key.
  typedef enum logic [1:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk
  } ps2_state_e;

  // Decoded key event; 'rel' is the key-release flag (release is a keyword).
  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_event_t;

  // Odd parity holds when the 8 data bits plus parity bit have odd weight.
  function automatic logic ps2_odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous event FIFO with occupancy count and sticky overflow flag.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_wr_en,
  input  ps2_event_t                      i_wr_data,
  input  logic                            i_rd_en,
  output ps2_event_t                      o_rd_data,
  output logic                            o_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_count,
  output logic                            o_overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  ps2_event_t    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          w_full;
  logic          w_empty;
  logic          w_rd;
  logic          w_wr;

  // A read frees a slot in the same cycle, so a full FIFO still accepts a write.
  always_comb begin
    w_full  = (r_count == CW'(FIFO_DEPTH));
    w_empty = (r_count == '0);
    w_rd    = i_rd_en & ~w_empty;
    w_wr    = i_wr_en & (~w_full | w_rd);
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (i_wr_en && w_full && !w_rd) r_overflow <= 1'b1;
    end
  end

  // Storage array; contents need no reset since the head is gated by empty.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_empty    = w_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises the lines, frames 11-bit words, folds
// E0/F0 prefixes into key events and buffers them in a FIFO.
// Optional parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_ps2_clk,
  input  logic                            i_ps2_data,
  output logic [7:0]                      o_ev_code,
  output logic                            o_ev_ext,
  output logic                            o_ev_release,
  output logic                            o_ev_valid,
  input  logic                            i_ev_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_fifo_count,
  output logic                            o_overflow,
  output logic                            o_frame_err,
  output logic                            o_parity_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  logic                   r_strobe;
  logic                   r_bit;
  logic [3:0]             r_bit_cnt;
  logic [9:0]             r_shift;
  logic [TW-1:0]          r_to_cnt;
  logic                   r_frame_err;
  ps2_state_e             r_state;
  ps2_state_e             w_state_d;
  logic                   r_emit;
  ps2_event_t             r_emit_ev;
  logic                   w_emit;
  ps2_event_t             w_emit_ev;
  logic                   w_frame_done;
  logic                   w_framing_ok;
  logic                   w_par_ok;
  logic                   w_byte_ok;
  logic                   w_timeout;
  logic [7:0]             w_byte;
  ps2_event_t             w_head;
  logic                   w_empty;

  // Synchronisers idle high so reset release never fakes a falling edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
      r_strobe    <= 1'b0;
      r_bit       <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
      r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
      r_strobe    <= r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
      r_bit       <= r_data_sync[SYNC_STAGES-1];
    end
  end

  // Frame fields: r_shift[0]=start, [8:1]=data, [9]=parity; r_bit is the stop bit.
  always_comb begin
    w_frame_done = r_strobe && (r_bit_cnt == 4'd10);
    w_framing_ok = ~r_shift[0] & r_bit;
    w_byte       = r_shift[8:1];
    w_timeout    = !r_strobe && (r_bit_cnt != 4'd0) && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
  end

`ifdef PS2_PARITY_CHECK_EN
  assign w_par_ok = ps2_odd_parity_ok(r_shift[9:1]);
`else
  assign w_par_ok = 1'b1;
`endif

  assign w_byte_ok = w_frame_done & w_framing_ok & w_par_ok;

  // Bit counter, LSB-first shifter and in-frame idle timeout.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_to_cnt  <= '0;
    end else begin
      if (r_strobe) begin
        r_shift   <= {r_bit, r_shift[9:1]};
        r_bit_cnt <= (r_bit_cnt == 4'd10) ? 4'd0 : r_bit_cnt + 4'd1;
        r_to_cnt  <= '0;
      end else if (r_bit_cnt == 4'd0 || w_timeout) begin
        r_bit_cnt <= '0;
        r_to_cnt  <= '0;
      end else begin
        r_to_cnt  <= r_to_cnt + TW'(1);
      end
    end
  end

  // Prefix FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_d;
  end

  // Prefix FSM next state and event emission.
  always_comb begin
    w_state_d = r_state;
    w_emit    = 1'b0;
    w_emit_ev = '0;
    if (w_timeout) begin
      w_state_d = StIdle;
    end else if (w_byte_ok) begin
      if (w_byte == PS2_EXT_PREFIX) begin
        w_state_d = StExt;
      end else if (w_byte == PS2_BRK_PREFIX) begin
        case (r_state)
          StIdle:  w_state_d = StBrk;
          StExt:   w_state_d = StExtBrk;
          default: w_state_d = r_state;
        endcase
      end else begin
        w_emit         = 1'b1;
        w_emit_ev.code = w_byte;
        w_emit_ev.ext  = (r_state == StExt) || (r_state == StExtBrk);
        w_emit_ev.rel  = (r_state == StBrk) || (r_state == StExtBrk);
        w_state_d      = StIdle;
      end
    end
  end

  // Registered emit stage and error pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_emit      <= 1'b0;
      r_emit_ev   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_emit      <= w_emit;
      r_emit_ev   <= w_emit_ev;
      r_frame_err <= (w_frame_done & ~w_framing_ok) | w_timeout;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic r_parity_err;

  // Parity failure on an otherwise well-framed word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_parity_err <= 1'b0;
    else          r_parity_err <= w_frame_done & w_framing_ok & ~w_par_ok;
  end

  assign o_parity_err = r_parity_err;
`else
  assign o_parity_err = 1'b0;
`endif

  ps2_event_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_wr_en    (r_emit),
    .i_wr_data  (r_emit_ev),
    .i_rd_en    (i_ev_ready),
    .o_rd_data  (w_head),
    .o_empty    (w_empty),
    .o_count    (o_fifo_count),
    .o_overflow (o_overflow)
  );

  // Head outputs read as zero while the FIFO is empty.
  always_comb begin
    o_ev_valid   = ~w_empty;
    o_ev_code    = o_ev_valid ? w_head.code : 8'h00;
    o_ev_ext     = o_ev_valid & w_head.ext;
    o_ev_release = o_ev_valid & w_head.rel;
  end

  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder with a queue-based reference model.
module tb_ps2_key_decoder;

  localparam int S  = 3;
  localparam int T  = 50000;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);
  localparam int H  = 6;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ps2_clk;
  logic          ps2_data;
  logic          ev_ready;
  logic [7:0]    ev_code;
  logic          ev_ext;
  logic          ev_release;
  logic          ev_valid;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          frame_err;
  logic          parity_err;

  always #5 clk = ~clk;

  ps2_key_decoder #(
    .SYNC_STAGES    (S),
    .TIMEOUT_CYCLES (T),
    .FIFO_DEPTH     (D)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_data   (ps2_data),
    .o_ev_code    (ev_code),
    .o_ev_ext     (ev_ext),
    .o_ev_release (ev_release),
    .o_ev_valid   (ev_valid),
    .i_ev_ready   (ev_ready),
    .o_fifo_count (fifo_count),
    .o_overflow   (overflow),
    .o_frame_err  (frame_err),
    .o_parity_err (parity_err)
  );

  typedef struct {
    int         due;
    logic [9:0] ev;   // {ext, release, code}
  } pend_t;

  pend_t      pend_ev[$];
  int         pend_fe[$];
  int         pend_pe[$];
  logic [9:0] mq[$];
  bit         m_ovf;
  bit         exp_fe;
  bit         exp_pe;
  bit         m_ext;
  bit         m_brk;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         fe_seen = 0;
  bit         rand_rdy = 1'b0;
  bit         ready_req = 1'b0;
  bit         pulse_arm = 1'b0;
  int         stop_fall = -1000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: applies scheduled writes/errors and consumer pops each edge.
  always @(posedge clk) begin
    cyc    = cyc + 1;
    exp_fe = 1'b0;
    exp_pe = 1'b0;
    if (!rst_n) begin
      mq.delete();
      pend_ev.delete();
      pend_fe.delete();
      pend_pe.delete();
      m_ovf = 1'b0;
    end else begin
      if (mq.size() > 0 && ev_ready) void'(mq.pop_front());
      if (pend_ev.size() > 0 && pend_ev[0].due == cyc) begin
        if (mq.size() < D) mq.push_back(pend_ev[0].ev);
        else               m_ovf = 1'b1;
        void'(pend_ev.pop_front());
      end
      if (pend_fe.size() > 0 && pend_fe[0] == cyc) begin
        exp_fe = 1'b1;
        void'(pend_fe.pop_front());
      end
      if (pend_pe.size() > 0 && pend_pe[0] == cyc) begin
        exp_pe = 1'b1;
        void'(pend_pe.pop_front());
      end
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin : cmp_p
    logic       v;
    logic [9:0] h;
    if (rst_n) begin
      v = (mq.size() > 0);
      h = v ? mq[0] : 10'h000;
      chk("ev_valid", ev_valid, v);
      chk("fifo_count", fifo_count, mq.size());
      chk("ev_code", ev_code, h[7:0]);
      chk("ev_ext", ev_ext, h[9]);
      chk("ev_release", ev_release, h[8]);
      chk("overflow", overflow, m_ovf);
      chk("frame_err", frame_err, exp_fe);
      chk("parity_err", parity_err, exp_pe);
      if (frame_err) fe_seen++;
    end
  end

  // Sole driver of ev_ready: random, requested level, or a one-shot at a write.
  initial begin
    ev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rand_rdy) ev_ready = 1'($urandom_range(0, 1));
      else          ev_ready = ready_req | (pulse_arm && (cyc == stop_fall + S + 2));
    end
  end

  // Decode a completed frame from the protocol rules; 'n' is the processing edge.
  task automatic model_frame(input logic [7:0] b, input bit bad_frm, input bit bad_par,
                             input int n);
    pend_t p;
    if (bad_frm) begin
      pend_fe.push_back(n);
    end else if (bad_par && PAR_EN) begin
      pend_pe.push_back(n);
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
      m_brk = 1'b0;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      p.due = n + 1;
      p.ev  = {m_ext, m_brk, b};
      pend_ev.push_back(p);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_start, input bit bad_par,
                            input bit bad_stop, input int nbits, input bit expect_to);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, bad_start};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) ps2_data = f[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == nbits - 1) begin
        stop_fall = cyc;
        if (nbits == 11) begin
          model_frame(b, bad_start | bad_stop, bad_par, cyc + S + 2);
        end else if (expect_to) begin
          pend_fe.push_back(cyc + S + 2 + T);
          m_ext = 1'b0;
          m_brk = 1'b0;
        end
      end
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic key(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 1'b0, 11, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst ev_valid", ev_valid, 1'b0);
    chk("rst ev_code", ev_code, 8'h00);
    chk("rst ev_ext", ev_ext, 1'b0);
    chk("rst ev_release", ev_release, 1'b0);
    chk("rst fifo_count", fifo_count, 0);
    chk("rst overflow", overflow, 1'b0);
    chk("rst frame_err", frame_err, 1'b0);
    chk("rst parity_err", parity_err, 1'b0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    m_ext    = 1'b0;
    m_brk    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    idle(5);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0;
    logic [7:0] b;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    idle(4);
    check_reset_outputs();
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(5);

    // Single make code.
    key(8'h1C);
    idle(6);
    chk("1C valid", ev_valid, 1'b1);
    chk("1C code", ev_code, 8'h1C);
    chk("1C flags", {ev_ext, ev_release}, 2'b00);
    chk("1C count", fifo_count, 1);
    ready_req = 1'b1;
    idle(3);
    ready_req = 1'b0;

    // Extended release folds into one event and holds while not ready.
    key(8'hE0);
    key(8'hF0);
    key(8'h75);
    idle(6);
    chk("E0F075 code", ev_code, 8'h75);
    chk("E0F075 flags", {ev_ext, ev_release}, 2'b11);
    chk("E0F075 count", fifo_count, 1);
    idle(20);
    chk("E0F075 held", {ev_valid, ev_ext, ev_release, ev_code}, {3'b111, 8'h75});
    ready_req = 1'b1;
    idle(3);
    chk("E0F075 drained", ev_valid, 1'b0);

    // Bad stop bit, then stalled partial frame after a pending F0, then recovery.
    fe0 = fe_seen;
    send_frame(8'h1C, 1'b0, 1'b0, 1'b1, 11, 1'b0);
    idle(8);
    chk("stop err pulses", fe_seen, fe0 + 1);
    chk("stop err no event", ev_valid, 1'b0);
    key(8'hF0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 6, 1'b1);
    idle(T + 20);
    chk("timeout pulses", fe_seen, fe0 + 2);
    ready_req = 1'b0;
    key(8'h29);
    idle(6);
    chk("29 after timeout", {ev_valid, ev_ext, ev_release, ev_code}, {3'b100, 8'h29});
    ready_req = 1'b1;
    idle(3);

    // Parity: F0, then 1C with wrong parity, then a good 1C.
    ready_req = 1'b0;
    key(8'hF0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 11, 1'b0);
    idle(4);
    key(8'h1C);
    idle(6);
    chk("parity head", {ev_valid, ev_ext, ev_release, ev_code}, {3'b101, 8'h1C});
    chk("parity count", fifo_count, PAR_EN ? 1 : 2);
    ready_req = 1'b1;
    idle(4);

    // Overflow: five keys into a four-deep FIFO with no consumer.
    ready_req = 1'b0;
    key(8'h15);
    key(8'h1D);
    key(8'h24);
    key(8'h2D);
    key(8'h2C);
    idle(6);
    chk("ovf count", fifo_count, 4);
    chk("ovf flag", overflow, 1'b1);
    chk("ovf head", ev_code, 8'h15);
    ready_req = 1'b1;
    idle(8);
    ready_req = 1'b0;

    // Full FIFO with a pop on the exact write cycle: no drop.
    pulse_reset();
    key(8'h16);
    key(8'h1E);
    key(8'h26);
    key(8'h25);
    pulse_arm = 1'b1;
    key(8'h2E);
    idle(6);
    pulse_arm = 1'b0;
    chk("full rw count", fifo_count, 4);
    chk("full rw no ovf", overflow, 1'b0);
    chk("full rw head", ev_code, 8'h1E);

    // Reset mid-frame with the FIFO occupied.
    send_frame(8'h36, 1'b0, 1'b0, 1'b0, 5, 1'b0);
    pulse_reset();
    key(8'h1C);
    idle(6);
    chk("post reset 1C", {ev_valid, ev_ext, ev_release, ev_code}, {3'b100, 8'h1C});
    chk("post reset count", fifo_count, 1);

    // Randomised traffic with a random consumer.
    rand_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 20)      b = 8'hE0;
      else if (r < 35) b = 8'hF0;
      else             b = 8'($urandom_range(0, 255));
      send_frame(b, ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 15) == 0), 11, 1'b0);
      idle($urandom_range(4, 40));
    end
    rand_rdy  = 1'b0;
    ready_req = 1'b1;
    idle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Parametrised PS/2 keyboard receiver and scan-code decoder. It samples the PS/2 clock/data lines, validates 11-bit frames (start, parity, stop), recovers from stalled frames with a timeout, and folds `E0`/`F0` prefixes into single key events. Events are buffered in a FIFO and drained through a valid/ready handshake. It sits between the keyboard pins and the game-select / player-input logic of the arcade.

## Interface
- `SYNC_STAGES`, 3: synchroniser depth for `ps2_clk` and `ps2_data`; ≥2.
- `TIMEOUT_CYCLES`, 50000: idle `clk` cycles inside a frame before it is abandoned; ≥16.
- `FIFO_DEPTH`, 8: event FIFO entries; power of two, ≥2.
- `clk` in 1: system clock; single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `ps2_clk` in 1: raw PS/2 clock line (asynchronous).
- `ps2_data` in 1: raw PS/2 data line (asynchronous).
- `ev_code` out 8: scan code of the FIFO head event.
- `ev_ext` out 1: head event was `E0`-prefixed.
- `ev_release` out 1: head event was `F0`-prefixed (key release).
- `ev_valid` out 1: FIFO not empty.
- `ev_ready` in 1: consumer accepts the head event.
- `fifo_count` out $clog2(FIFO_DEPTH+1): occupied entries.
- `overflow` out 1: sticky; set when an event is dropped on a full FIFO.
- `frame_err` out 1: 1-cycle pulse on bad start/stop bit or timeout.
- `parity_err` out 1: 1-cycle pulse on odd-parity failure.

## Operation
- Both lines pass through `SYNC_STAGES` flops. The edge strobe is taken where the last two synchronised `ps2_clk` samples are 1→0. Data is sampled from the same synchroniser stage as the edge, so the two stay aligned.
- Bit counter runs 0..10 and shifts LSB-first. On bit 10:
  - require start=0 and stop=1, otherwise pulse `frame_err` and discard;
  - check parity (see Configuration);
  - on success, pass the byte to the prefix FSM;
  - bit counter returns to 0 in all cases.
- Timeout counter:
  - clears on every edge strobe;
  - counts only while bit counter ≠ 0;
  - on reaching `TIMEOUT_CYCLES`: bit counter → 0, prefix FSM → IDLE, pulse `frame_err`.
- Prefix FSM states: IDLE, EXT, BRK, EXT_BRK.
  - `E0` from any state → EXT.
  - `F0`: IDLE→BRK, EXT→EXT_BRK, BRK/EXT_BRK stay.
  - Any other byte emits event {code, ext = state∈{EXT,EXT_BRK}, release = state∈{BRK,EXT_BRK}} and → IDLE.
  - Prefix bytes never emit events.
- FIFO:
  - write on emit; read when `ev_valid && ev_ready`.
  - Write while full with no simultaneous read: event dropped, `overflow` set.
  - Write and read in the same cycle while full: both succeed, count unchanged.
  - Read when empty: ignored.
  - Pointers wrap modulo `FIFO_DEPTH`.
- `ev_*` outputs reflect the FIFO head and are held stable while `ev_valid && !ev_ready`.

## Timing
- Reset values:
  - `ev_valid`=0, `ev_code`=0, `ev_ext`=0, `ev_release`=0;
  - `fifo_count`=0, `overflow`=0, `frame_err`=0, `parity_err`=0;
  - FSM in IDLE; bit, timeout and pointer counters all 0.
- Reset asserted mid-frame or with the FIFO occupied discards everything. After deassertion the first falling edge is treated as a start bit.
- Edge strobe lags the raw `ps2_clk` fall by `SYNC_STAGES`+1 cycles.
- Stop-bit strobe at cycle N:
  - emitted event written at N+1;
  - `ev_valid`/`fifo_count` updated at N+2.
- Error pulses are registered and high for exactly cycle N+1.
- Handshake: the FIFO pops on the cycle where `ev_valid && ev_ready` is sampled high. The next head appears the following cycle. Sustained throughput is 1 event/cycle.

## Configuration
- `PS2_PARITY_CHECK_EN` defined:
  - a frame whose 8 data bits plus parity bit have even weight is discarded;
  - `parity_err` pulses and the prefix FSM is unchanged.
- `PS2_PARITY_CHECK_EN` undefined:
  - the parity bit is ignored;
  - `parity_err` is tied to 0.

## Structure
- Package `ps2_pkg`:
  - constants `PS2_EXT_PREFIX`=8'hE0 and `PS2_BRK_PREFIX`=8'hF0;
  - prefix FSM state enum;
  - event struct {ext, release, code[7:0]}, 10 bits.
- Sub-module `ps2_event_fifo`: synchronous FIFO parametrised by `FIFO_DEPTH`, 10-bit data. Provides count, full/empty, and the overflow flag.

## Test plan
- Frame `1C` (parity 0, stop 1) → one event {code=1C, ext=0, release=0}; `ev_valid` high at N+2; `fifo_count`=1.
- Sequence `E0 F0 75` with `ev_ready`=0 → exactly one event {75, ext=1, release=1}. Outputs stay stable until `ev_ready`=1, then `ev_valid`=0.
- Frame `1C` with stop bit 0 → `frame_err` pulses 1 cycle, no event. Then 6 bits of a frame followed by 50000 idle cycles → `frame_err`. Next valid `29` decodes correctly.
- With `PS2_PARITY_CHECK_EN`: `1C` sent with parity 1 → `parity_err` pulse, no event, and a preceding `F0` is still pending. Without the macro the same frame → event 1C.
- `FIFO_DEPTH`=4, 5 key codes, `ev_ready`=0 → `fifo_count`=4, `overflow`=1, the first four codes drain in order.
- FIFO full, `ev_ready`=1 on the same cycle as a new write → count stays 4, no overflow. Assert `rst_n`=0 mid-frame → all outputs return to reset values.
